// File: rtl/bilinear_pkg.sv
// Shared types, Q-format helpers and the bilinear blend used by the SIMD downscale core.
package bilinear_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COMP
    } state_t;

    localparam int FRAC_BITS_DEF = 8;
    localparam int ONE_Q         = 1 << FRAC_BITS_DEF;
    localparam int HALF_Q        = ONE_Q >> 1;

    localparam int N00 = 0;
    localparam int N10 = 1;
    localparam int N01 = 2;
    localparam int N11 = 3;

    function automatic int one_q(input int f);
        return 1 << f;
    endfunction

    function automatic int half_q(input int f);
        return 1 << (f - 1);
    endfunction

    // Weighted sum of the four neighbours, rounded to nearest and saturated to pix_w bits.
    function automatic logic [31:0] blend(input logic [31:0] d00, input logic [31:0] d10,
                                          input logic [31:0] d01, input logic [31:0] d11,
                                          input logic [31:0] tx,  input logic [31:0] ty,
                                          input int f, input int pix_w);
        logic [63:0] one;
        logic [63:0] w00;
        logic [63:0] w10;
        logic [63:0] w01;
        logic [63:0] w11;
        logic [63:0] acc;
        logic [63:0] pmax;
        one  = 64'd1 << f;
        w00  = (one - 64'(tx)) * (one - 64'(ty));
        w10  = 64'(tx) * (one - 64'(ty));
        w01  = (one - 64'(tx)) * 64'(ty);
        w11  = 64'(tx) * 64'(ty);
        acc  = 64'(d00) * w00 + 64'(d10) * w10 + 64'(d01) * w01 + 64'(d11) * w11
             + (64'd1 << (2 * f - 1));
        acc  = acc >> (2 * f);
        pmax = (64'd1 << pix_w) - 64'd1;
        return (acc > pmax) ? pmax[31:0] : acc[31:0];
    endfunction

endpackage

// File: rtl/bilinear_core_simd_if.sv
// Image-BRAM read ports and output-writer bus of the SIMD bilinear core.
interface bilinear_core_simd_if #(
    parameter int LANES  = 4,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 32
);
    logic [LANES*4*ADDR_W-1:0] rd_addr;
    logic [LANES*4*PIX_W-1:0]  rd_data;
    logic [LANES-1:0]          wr_valid;
    logic [ADDR_W-1:0]         wr_addr;
    logic [LANES*PIX_W-1:0]    wr_data;

    modport master (
        output rd_addr,
        input  rd_data,
        output wr_valid,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  wr_valid,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/bilinear_lane_calc.sv
// Per-lane source coordinate mapping: four clamped neighbour addresses and x/y fractions.
// Purely combinational; no state, no backpressure.
module bilinear_lane_calc
    import bilinear_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int DIM_W     = 16,
    parameter int ADDR_W    = 32
) (
    input  logic [DIM_W-1:0]       xo,
    input  logic [DIM_W-1:0]       yo,
    input  logic [DIM_W-1:0]       in_w,
    input  logic [DIM_W-1:0]       in_h,
    input  logic [15:0]            inv_x,
    input  logic [15:0]            inv_y,
    output logic [3:0][ADDR_W-1:0] addr,
    output logic [FRAC_BITS-1:0]   tx,
    output logic [FRAC_BITS-1:0]   ty
);
    localparam logic signed [47:0] HALF = 48'(half_q(FRAC_BITS));

    // Pixel-centre aligned mapping: ((o + 0.5) * inv) - 0.5 in Q.FRAC_BITS.
    function automatic logic signed [47:0] src_pos(input logic [DIM_W-1:0] o,
                                                   input logic [15:0] inv);
        logic signed [47:0] t;
        t = $signed(48'(o)) <<< FRAC_BITS;
        t = ((t + HALF) * $signed(48'(inv))) >>> FRAC_BITS;
        return t - HALF;
    endfunction

    function automatic logic [DIM_W-1:0] clamp_int(input logic signed [47:0] p,
                                                   input logic [DIM_W-1:0] dim);
        logic signed [47:0] ip;
        logic signed [47:0] lim;
        ip  = p >>> FRAC_BITS;
        lim = $signed(48'(dim)) - 48'sd1;
        if (ip < 48'sd0)
            return '0;
        else if (ip > lim)
            return lim[DIM_W-1:0];
        return ip[DIM_W-1:0];
    endfunction

    function automatic logic [FRAC_BITS-1:0] frac(input logic signed [47:0] p);
        return (p < 48'sd0) ? '0 : p[FRAC_BITS-1:0];
    endfunction

    function automatic logic [DIM_W-1:0] next_idx(input logic [DIM_W-1:0] i,
                                                  input logic [DIM_W-1:0] dim);
        return ({1'b0, i} + 1'b1 < {1'b0, dim}) ? i + 1'b1 : i;
    endfunction

    logic signed [47:0] xs;
    logic signed [47:0] ys;
    logic [DIM_W-1:0]   x0;
    logic [DIM_W-1:0]   x1;
    logic [DIM_W-1:0]   y0;
    logic [DIM_W-1:0]   y1;
    logic [ADDR_W-1:0]  row0;
    logic [ADDR_W-1:0]  row1;

    always_comb begin
        xs   = src_pos(xo, inv_x);
        ys   = src_pos(yo, inv_y);
        x0   = clamp_int(xs, in_w);
        y0   = clamp_int(ys, in_h);
        x1   = next_idx(x0, in_w);
        y1   = next_idx(y0, in_h);
        row0 = ADDR_W'(y0) * ADDR_W'(in_w);
        row1 = ADDR_W'(y1) * ADDR_W'(in_w);
        addr[N00] = row0 + ADDR_W'(x0);
        addr[N10] = row0 + ADDR_W'(x1);
        addr[N01] = row1 + ADDR_W'(x0);
        addr[N11] = row1 + ADDR_W'(x1);
        tx = frac(xs);
        ty = frac(ys);
    end

endmodule

// File: rtl/bilinear_core_simd.sv
// Multi-lane bilinear downscaler: LANES output pixels every 2 cycles (ISSUE then COMP).
// First write 3 cycles after start; no backpressure, optional step/step_ack single-stepping.
module bilinear_core_simd
    import bilinear_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int PIX_W     = 8,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ADDR_W    = 32,
    parameter int DIM_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DIM_W-1:0]       in_w,
    input  logic [DIM_W-1:0]       in_h,
    input  logic [DIM_W-1:0]       out_w,
    input  logic [DIM_W-1:0]       out_h,
    input  logic [15:0]            inv_scale_x_q,
    input  logic [15:0]            inv_scale_y_q,
    input  logic                   step_mode,
    input  logic                   step,
    output logic                   step_ack,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    bilinear_core_simd_if.master   bus
);
    state_t state;
    state_t state_nxt;

    logic [DIM_W-1:0] cur_x;
    logic [DIM_W-1:0] cur_y;
    logic [DIM_W-1:0] cur_x_nxt;
    logic [DIM_W-1:0] cur_y_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             cfg_err_nxt;
    logic             load_addr;
    logic             advance;
    logic             row_wrap;
    logic             last_row;

    logic [LANES-1:0][3:0][ADDR_W-1:0]  calc_addr;
    logic [LANES-1:0][FRAC_BITS-1:0]    calc_tx;
    logic [LANES-1:0][FRAC_BITS-1:0]    calc_ty;
    logic [LANES-1:0][3:0][ADDR_W-1:0]  rd_addr_q;
    logic [LANES-1:0][FRAC_BITS-1:0]    tx_q;
    logic [LANES-1:0][FRAC_BITS-1:0]    ty_q;

    logic [LANES-1:0]       wr_valid_q;
    logic [LANES-1:0]       wr_valid_nxt;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic [ADDR_W-1:0]      wr_addr_nxt;
    logic [LANES*PIX_W-1:0] wr_data_q;
    logic [LANES*PIX_W-1:0] wr_data_nxt;

    assign bus.rd_addr  = rd_addr_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bilinear_lane_calc #(
            .FRAC_BITS (FRAC_BITS),
            .DIM_W     (DIM_W),
            .ADDR_W    (ADDR_W)
        ) u_calc (
            .xo    (cur_x + DIM_W'(l)),
            .yo    (cur_y),
            .in_w  (in_w),
            .in_h  (in_h),
            .inv_x (inv_scale_x_q),
            .inv_y (inv_scale_y_q),
            .addr  (calc_addr[l]),
            .tx    (calc_tx[l]),
            .ty    (calc_ty[l])
        );
    end

    // In stepping mode only the rising half of a step handshake moves the FSM.
    assign advance  = !step_mode || (step && !step_ack);
    assign row_wrap = ({1'b0, cur_x} + (DIM_W+1)'(LANES)) >= {1'b0, out_w};
    assign last_row = ({1'b0, cur_y} + 1'b1) >= {1'b0, out_h};

    always_comb begin
        state_nxt    = state;
        cur_x_nxt    = cur_x;
        cur_y_nxt    = cur_y;
        busy_nxt     = busy;
        done_nxt     = done;
        cfg_err_nxt  = cfg_err;
        load_addr    = 1'b0;
        wr_valid_nxt = '0;
        wr_addr_nxt  = wr_addr_q;
        wr_data_nxt  = wr_data_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (in_w == '0 || in_h == '0 || out_w == '0 || out_h == '0) begin
                        done_nxt    = 1'b1;
                        cfg_err_nxt = 1'b1;
                    end else begin
                        busy_nxt    = 1'b1;
                        done_nxt    = 1'b0;
                        cfg_err_nxt = 1'b0;
                        cur_x_nxt   = '0;
                        cur_y_nxt   = '0;
                        state_nxt   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                load_addr = 1'b1;
                state_nxt = S_COMP;
            end
            S_COMP: begin
                wr_addr_nxt = ADDR_W'(cur_y) * ADDR_W'(out_w) + ADDR_W'(cur_x);
                for (int l = 0; l < LANES; l++) begin
                    wr_valid_nxt[l] = ({1'b0, cur_x} + (DIM_W+1)'(l)) < {1'b0, out_w};
                    wr_data_nxt[l*PIX_W +: PIX_W] = PIX_W'(blend(
                        32'(bus.rd_data[(4*l+N00)*PIX_W +: PIX_W]),
                        32'(bus.rd_data[(4*l+N10)*PIX_W +: PIX_W]),
                        32'(bus.rd_data[(4*l+N01)*PIX_W +: PIX_W]),
                        32'(bus.rd_data[(4*l+N11)*PIX_W +: PIX_W]),
                        32'(tx_q[l]), 32'(ty_q[l]), FRAC_BITS, PIX_W));
                end
                state_nxt = S_ISSUE;
                if (row_wrap) begin
                    cur_x_nxt = '0;
                    cur_y_nxt = cur_y + 1'b1;
                    if (last_row) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cur_x_nxt = cur_x + DIM_W'(LANES);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            step_ack   <= 1'b0;
            rd_addr_q  <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            wr_valid_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            if (!step_mode)
                step_ack <= 1'b0;
            else if (step && !step_ack)
                step_ack <= 1'b1;
            else if (!step && step_ack)
                step_ack <= 1'b0;

            // wr_valid is a strobe: it only survives the cycle right after a COMP transition.
            wr_valid_q <= '0;
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (advance) begin
                state      <= state_nxt;
                cur_x      <= cur_x_nxt;
                cur_y      <= cur_y_nxt;
                busy       <= busy_nxt;
                done       <= done_nxt;
                cfg_err    <= cfg_err_nxt;
                wr_valid_q <= wr_valid_nxt;
                wr_addr_q  <= wr_addr_nxt;
                wr_data_q  <= wr_data_nxt;
                if (load_addr) begin
                    rd_addr_q <= calc_addr;
                    tx_q      <= calc_tx;
                    ty_q      <= calc_ty;
                end
            end
        end
    end

endmodule
